// File: rtl/child_fanin_merger.sv
// Round-robin fan-in of NUM_CHILD valid/ready child streams into one registered
// output word, tagged with the index of the child that supplied it.
module child_fanin_merger #(
    parameter int NUM_CHILD = 5,
    parameter int DATA_W    = 16,
    parameter int SRC_W     = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CHILD-1:0]        in_valid,
    input  logic [NUM_CHILD*DATA_W-1:0] in_data,
    output logic [NUM_CHILD-1:0]        in_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [SRC_W-1:0]            out_src,
    input  logic                        out_ready,
    output logic [15:0]                 word_count
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [SRC_W-1:0]  r_src;
    logic [SRC_W-1:0]  r_ptr;
    logic [15:0]       r_count;

    logic              w_hi_any;
    logic              w_lo_any;
    logic [SRC_W-1:0]  w_hi;
    logic [SRC_W-1:0]  w_lo;
    logic              w_any;
    logic [SRC_W-1:0]  w_grant;
    logic              w_load;
    logic              w_take;
    logic [DATA_W-1:0] w_sel_data;
    logic [SRC_W-1:0]  w_next_ptr;

    // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        w_hi_any = 1'b0;
        w_lo_any = 1'b0;
        w_hi     = '0;
        w_lo     = '0;
        for (int j = NUM_CHILD - 1; j >= 0; j--) begin
            if (in_valid[j]) begin
                w_lo_any = 1'b1;
                w_lo     = SRC_W'(j);
                if (SRC_W'(j) >= r_ptr) begin
                    w_hi_any = 1'b1;
                    w_hi     = SRC_W'(j);
                end
            end
        end
        w_any   = w_lo_any;
        w_grant = w_hi_any ? w_hi : w_lo;
    end

    assign w_load = ~r_valid | out_ready;
    assign w_take = w_any & w_load & ~rst;

    always_comb begin
        in_ready   = '0;
        w_sel_data = '0;
        for (int j = 0; j < NUM_CHILD; j++) begin
            if (w_grant == SRC_W'(j)) begin
                in_ready[j] = w_take;
                w_sel_data  = in_data[j*DATA_W +: DATA_W];
            end
        end
    end

    assign w_next_ptr = (w_grant == SRC_W'(NUM_CHILD - 1)) ? '0 : w_grant + SRC_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= '0;
            r_ptr   <= '0;
            r_count <= '0;
        end else if (w_take) begin
            r_valid <= 1'b1;
            r_data  <= w_sel_data;
            r_src   <= w_grant;
            r_ptr   <= w_next_ptr;
            r_count <= r_count + 16'd1;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid  = r_valid;
    assign out_data   = r_data;
    assign out_src    = r_src;
    assign word_count = r_count;

endmodule

// File: doc/child_fanin_merger.md
# child_fanin_merger

Round-robin fan-in merger that collects data words from NUM_CHILD child instances into one registered output stream tagged with the source index. It sits in a root module, directly above its child instances. The root module broadcasts structure downward. This block carries traffic upward from the children to the root. Each input and the output use a valid/ready handshake, and the output holds one registered word.

## Interface
Parameters:
- NUM_CHILD, 5: number of child input channels (2..8).
- DATA_W, 16: data word width.
- SRC_W, 3: width of source tag; must satisfy 2**SRC_W >= NUM_CHILD.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  NUM_CHILD  per-child word valid.
- in_data  input  NUM_CHILD*DATA_W  per-child words; child i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  NUM_CHILD  per-child accept; one-hot or zero.
- out_valid  output  1  registered word available.
- out_data  output  DATA_W  registered word.
- out_src  output  SRC_W  index of the child that supplied out_data.
- out_ready  input  1  downstream accept.
- word_count  output  16  number of words accepted from children since reset; wraps modulo 2**16.

## Operation
- Transfer rules:
  - Input transfer on child i: in_valid[i] & in_ready[i] at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
- Load enable: load_en = ~out_valid | out_ready. The output register can take a new word when it is empty or being drained in the same cycle.
- Arbitration:
  - Combinational, round-robin over in_valid.
  - The search starts at index ptr and proceeds ptr, ptr+1, …, NUM_CHILD-1, 0, …, ptr-1.
  - The first valid index found is the grant g.
- in_ready:
  - in_ready[g] = load_en when any in_valid is set.
  - All other in_ready bits are 0.
  - in_ready is all-zero when no in_valid is set.
- On an input transfer from child g:
  - out_data <= in_data[g].
  - out_src <= g.
  - out_valid <= 1.
  - ptr <= (g+1) mod NUM_CHILD.
  - word_count <= word_count+1.
- Output transfer without a simultaneous input transfer: out_valid <= 0. out_data and out_src keep their values.
- Output transfer with a simultaneous input transfer: the register is overwritten with the new word and out_valid stays 1. There is no bubble.
- No valid inputs: ptr is unchanged and no state changes except any output drain.
- Child protocol: once in_valid[i] is raised, the child keeps it and in_data slice i stable until transfer. The merger does not check this.
- Reset values: out_valid=0, out_data=0, out_src=0, ptr=0, word_count=0.
- Reset mid-operation: a held output word is discarded without handshake. The next cycle after reset deasserts starts arbitration at child 0.

## Timing
- Latency: input transfer at edge N makes out_valid=1 after edge N, with the word visible in cycle N+1.
- Throughput: one word per cycle while out_ready=1 and any child is valid.
- Fairness: with all children continuously valid and out_ready=1, grants cycle 0,1,…,NUM_CHILD-1,0,…. Each child is served exactly once per NUM_CHILD cycles.
- Backpressure: out_valid=1 and out_ready=0 force all in_ready to 0. out_valid, out_data and out_src then stay stable until the output transfer.
- in_ready has a combinational path from in_valid and out_ready. Every other output is registered.
- word_count wraps from 0xFFFF to 0x0000 with no flag.

## Test plan
- Reset: hold rst=1 for 2 cycles with random inputs. Required: out_valid=0, out_data=0, out_src=0, word_count=0, in_ready=0 during reset.
- Single child: in_valid=5'b00100, in_data slice 2=0xBEEF, out_ready=1. Required:
  - in_ready=5'b00100 in the same cycle.
  - The next cycle shows out_valid=1, out_data=0xBEEF, out_src=2, word_count=1.
- Round-robin, all valid: all 5 children valid with data 0x1000+i, out_ready=1 for 10 cycles. Required: out_src sequence 0,1,2,3,4,0,1,2,3,4 with matching data, and word_count=10.
- Backpressure: with out_valid=1 and out_src=1, hold out_ready=0 for 4 cycles while children 3 and 4 are valid. Required:
  - in_ready=0 throughout, and out_data/out_src stay stable.
  - Raising out_ready gives the next grant to child 3.
- Pointer skip: ptr=3, only children 0 and 1 valid. Required: grant 0 then 1. ptr ends at 2.
- Wrap and reset mid-flight: preload 65535 transfers, then one more. Required: word_count=0. Then assert rst while out_valid=1 and out_ready=0. Required: out_valid=0 next cycle, and the first grant after reset goes to the lowest valid index starting from 0.
